// File: rtl/mdu_pkg.sv
// Shared types for the multiply/divide unit: op encodings, datapath opcodes, FSM state.
// The accumulate ops (madd/msub) are only active when MDU_MADD_EN is defined.
package mdu_pkg;

  localparam int CNT_W = 6;

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101,
    OP_MADD  = 3'b110,
    OP_MSUB  = 3'b111
  } mdu_op_e;

  typedef enum logic [1:0] {
    A2_MULTU = 2'b00,
    A2_MULT  = 2'b01,
    A2_DIVU  = 2'b10,
    A2_DIV   = 2'b11
  } alu2_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  // madd/msub reuse the signed multiplier
  function automatic alu2_op_e alu2_enc(input mdu_op_e o);
    alu2_op_e r;
    case (o)
      OP_MULTU: r = A2_MULTU;
      OP_DIV:   r = A2_DIV;
      OP_DIVU:  r = A2_DIVU;
      default:  r = A2_MULT;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mdu_lat_cnt.sv
// Latency down-counter for the mul/div unit: loaded on acceptance, saturates at zero.
module mdu_lat_cnt
  import mdu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] count_r;

  // count register: reload wins over decrement, never wraps below zero
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= {CNT_W{1'b0}};
    end else if (load) begin
      count_r <= value;
    end else if (dec && (count_r != {CNT_W{1'b0}})) begin
      count_r <= count_r - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign zero = (count_r == {CNT_W{1'b0}});

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide control: IDLE/RUN FSM, latched datapath operands and HI/LO registers.
// Define MDU_MADD_EN to enable madd/msub accumulation into {hi,lo}.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 33
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cancel,
  output logic [31:0] alu2_a,
  output logic [31:0] alu2_b,
  output logic [1:0]  alu2_op,
  input  logic [63:0] alu2_c,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

  mdu_state_e       state_r;
  mdu_op_e          op_s;
  logic             acc_r;
  logic             sub_r;
  logic             accept_s;
  logic             divz_s;
  logic             acc_s;
  logic             sub_s;
  logic             wr_hi_s;
  logic             wr_lo_s;
  logic [CNT_W-1:0] load_val_s;
  logic             cnt_zero_s;
  logic [63:0]      hilo_next_s;

  assign op_s = mdu_op_e'(op);

  // decode a start request seen in IDLE; cancel drops it entirely
  always_comb begin
    accept_s   = 1'b0;
    divz_s     = 1'b0;
    acc_s      = 1'b0;
    sub_s      = 1'b0;
    wr_hi_s    = 1'b0;
    wr_lo_s    = 1'b0;
    load_val_s = MUL_LOAD;
    if ((state_r == ST_IDLE) && start && !cancel) begin
      case (op_s)
        OP_MULT, OP_MULTU: accept_s = 1'b1;
        OP_DIV, OP_DIVU: begin
          load_val_s = DIV_LOAD;
          if (b == 32'd0) begin
            divz_s = 1'b1;
          end else begin
            accept_s = 1'b1;
          end
        end
        OP_MTHI: wr_hi_s = 1'b1;
        OP_MTLO: wr_lo_s = 1'b1;
        OP_MADD, OP_MSUB: begin
`ifdef MDU_MADD_EN
          accept_s = 1'b1;
          acc_s    = 1'b1;
          sub_s    = (op_s == OP_MSUB);
`else
          accept_s = 1'b0;
`endif
        end
        default: accept_s = 1'b0;
      endcase
    end else begin
      accept_s = 1'b0;
    end
  end

  // completion value: plain result or 64-bit modulo accumulate
  always_comb begin
    if (acc_r) begin
      if (sub_r) begin
        hilo_next_s = {hi, lo} - alu2_c;
      end else begin
        hilo_next_s = {hi, lo} + alu2_c;
      end
    end else begin
      hilo_next_s = alu2_c;
    end
  end

  mdu_lat_cnt u_lat_cnt (
    .clk   (clk),
    .rst   (rst),
    .load  (accept_s),
    .value (load_val_s),
    .dec   (state_r == ST_RUN),
    .zero  (cnt_zero_s)
  );

  // FSM with registered busy/done, datapath operand latches and HI/LO
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      hi      <= 32'd0;
      lo      <= 32'd0;
      alu2_a  <= 32'd0;
      alu2_b  <= 32'd0;
      alu2_op <= 2'b00;
      acc_r   <= 1'b0;
      sub_r   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            state_r <= ST_RUN;
            busy    <= 1'b1;
            alu2_a  <= a;
            alu2_b  <= b;
            alu2_op <= alu2_enc(op_s);
            acc_r   <= acc_s;
            sub_r   <= sub_s;
          end else if (divz_s) begin
            done <= 1'b1;
          end else if (wr_hi_s) begin
            hi <= a;
          end else if (wr_lo_s) begin
            lo <= a;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_RUN: begin
          // cancel beats completion in the same cycle
          if (cancel) begin
            state_r <= ST_IDLE;
            busy    <= 1'b0;
          end else if (cnt_zero_s) begin
            {hi, lo} <= hilo_next_s;
            done     <= 1'b1;
            state_r  <= ST_IDLE;
            busy     <= 1'b0;
          end else begin
            state_r <= ST_RUN;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: acts as the mul/div datapath and scoreboards HI/LO results.
module tb_mdu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        cancel;
  logic [31:0] alu2_a;
  logic [31:0] alu2_b;
  logic [1:0]  alu2_op;
  logic [63:0] alu2_c;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int tests = 0;
  int fails = 0;
  logic [63:0] sb[$];
  logic [31:0] exp_hi;
  logic [31:0] exp_lo;

  mdu_ctrl #(.MUL_LAT(4), .DIV_LAT(33)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .cancel(cancel),
    .alu2_a(alu2_a), .alu2_b(alu2_b), .alu2_op(alu2_op), .alu2_c(alu2_c),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // reference datapath
  logic signed [63:0] sa64, sb64;
  logic signed [31:0] sq, sr;
  assign sa64 = {{32{alu2_a[31]}}, alu2_a};
  assign sb64 = {{32{alu2_b[31]}}, alu2_b};
  assign sq = (alu2_b == 32'd0) ? 32'sd0 : $signed(alu2_a) / $signed(alu2_b);
  assign sr = (alu2_b == 32'd0) ? 32'sd0 : $signed(alu2_a) % $signed(alu2_b);

  always_comb begin
    case (alu2_op)
      2'b00:   alu2_c = {32'd0, alu2_a} * {32'd0, alu2_b};
      2'b01:   alu2_c = sa64 * sb64;
      2'b10:   alu2_c = (alu2_b == 32'd0) ? 64'd0 : {alu2_a % alu2_b, alu2_a / alu2_b};
      default: alu2_c = {sr, sq};
    endcase
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_hilo(input string tag);
    chk(tag, {hi, lo}, {exp_hi, exp_lo});
  endtask

  // issue a mul/div, count busy cycles, then compare against the scoreboard
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input int lat, input logic [1:0] aop, input logic [63:0] exp,
                        input string tag);
    int n;
    logic [63:0] e;
    sb.push_back(exp);
    start = 1'b1; op = o; a = x; b = y;
    tick();
    start = 1'b0; a = 32'd0; b = 32'd0;
    chk({tag, " alu2_op"}, 64'(alu2_op), 64'(aop));
    n = 0;
    while (busy && n < 200) begin
      n++;
      if (done) chk({tag, " early done"}, 64'(done), 64'd0);
      tick();
    end
    chk({tag, " busy cycles"}, 64'(n), 64'(lat));
    chk({tag, " operands held"}, {alu2_a, alu2_b}, {x, y});
    chk({tag, " done"}, 64'(done), 64'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      {exp_hi, exp_lo} = e;
      chk_hilo({tag, " hilo"});
    end else begin
      chk({tag, " scoreboard empty"}, 64'(sb.size()), 64'd1);
    end
    tick();
    chk({tag, " done pulse"}, 64'(done), 64'd0);
  endtask

  task automatic move(input logic [2:0] o, input logic [31:0] x, input string tag);
    start = 1'b1; op = o; a = x;
    tick();
    start = 1'b0;
    if (o == 3'b100) exp_hi = x; else exp_lo = x;
    chk({tag, " busy/done"}, {62'd0, busy, done}, 64'd0);
    chk_hilo({tag, " hilo"});
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 3'b000; a = 32'd0; b = 32'd0; cancel = 1'b0;
    exp_hi = 32'd0; exp_lo = 32'd0;
    tick();
    tick();
    rst = 1'b0;
    chk("reset busy/done", {62'd0, busy, done}, 64'd0);
    chk_hilo("reset hilo");
    chk("reset alu2", {alu2_a, alu2_b}, 64'd0);
    chk("reset alu2_op", 64'(alu2_op), 64'd0);

    run_op(3'b000, 32'hFFFF_FFFE, 32'd3, 4, 2'b01, 64'hFFFF_FFFF_FFFF_FFFA, "mult");
    run_op(3'b011, 32'd100, 32'd7, 33, 2'b10, {32'd2, 32'd14}, "divu");
    run_op(3'b010, 32'hFFFF_FFF9, 32'd2, 33, 2'b11, 64'hFFFF_FFFF_FFFF_FFFD, "div");

    move(3'b100, 32'd5, "mthi");
    move(3'b101, 32'd6, "mtlo");

    // divide by zero: done next cycle, no busy
    start = 1'b1; op = 3'b010; a = 32'd9; b = 32'd0;
    tick();
    start = 1'b0;
    chk("div0 busy/done", {62'd0, busy, done}, 64'd1);
    chk_hilo("div0 hilo");
    tick();
    chk("div0 pulse", {62'd0, busy, done}, 64'd0);

    // cancel in the third RUN cycle of a divide
    start = 1'b1; op = 3'b011; a = 32'd100; b = 32'd7;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("cancel3 busy before", 64'(busy), 64'd1);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    chk("cancel3 busy/done", {62'd0, busy, done}, 64'd0);
    chk_hilo("cancel3 hilo");
    tick();
    chk("cancel3 no late done", {62'd0, busy, done}, 64'd0);
    move(3'b101, 32'h0000_1234, "mtlo after cancel");

    // cancel on the final mult RUN cycle beats completion
    start = 1'b1; op = 3'b000; a = 32'd7; b = 32'd7;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    chk("cancel last busy", 64'(busy), 64'd1);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    chk("cancel last busy/done", {62'd0, busy, done}, 64'd0);
    chk_hilo("cancel last hilo");

    // cancel with start in IDLE drops a move
    start = 1'b1; op = 3'b100; a = 32'hDEAD; cancel = 1'b1;
    tick();
    start = 1'b0; cancel = 1'b0;
    chk_hilo("cancel+mthi hilo");

`ifdef MDU_MADD_EN
    move(3'b100, 32'd0, "mthi0");
    move(3'b101, 32'hFFFF_FFFF, "mtlo ones");
    run_op(3'b110, 32'd1, 32'd1, 4, 2'b01, {32'd1, 32'd0}, "madd");
    run_op(3'b111, 32'd1, 32'd1, 4, 2'b01, {32'd0, 32'hFFFF_FFFF}, "msub");
`else
    start = 1'b1; op = 3'b110; a = 32'd1; b = 32'd1;
    tick();
    start = 1'b0;
    chk("madd off busy/done", {62'd0, busy, done}, 64'd0);
    chk_hilo("madd off hilo");
    tick();
    chk("madd off later", {62'd0, busy, done}, 64'd0);
`endif

    // reset in the middle of a divide
    start = 1'b1; op = 3'b011; a = 32'd100; b = 32'd7;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_hi = 32'd0; exp_lo = 32'd0;
    chk("rst mid busy/done", {62'd0, busy, done}, 64'd0);
    chk_hilo("rst mid hilo");
    for (int i = 0; i < 40; i++) begin
      if (done || busy) chk("rst no done", {62'd0, busy, done}, 64'd0);
      tick();
    end
    chk_hilo("rst hilo held");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 The block SHALL have parameter MUL_LAT, default 4: multiply latency in cycles from acceptance to HI/LO write, range 1..63.
REQ-002 The block SHALL have parameter DIV_LAT, default 33: divide latency in cycles from acceptance to HI/LO write, range 1..63.
REQ-003 The block SHALL have input clk, 1 bit: the single clock, rising edge.
REQ-004 The block SHALL have input rst, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have input start, 1 bit: operation request, sampled in IDLE only.
REQ-006 The block SHALL have input op, 3 bits: 000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, 110 madd, 111 msub.
REQ-007 The block SHALL have inputs a and b, 32 bits each: operands, rs and rt.
REQ-008 The block SHALL have input cancel, 1 bit: exception flush that aborts an in-flight operation.
REQ-009 The block SHALL have outputs alu2_a and alu2_b, 32 bits each, and alu2_op, 2 bits: the latched operands and opcode for the shared mul/div datapath.
REQ-010 The block SHALL have input alu2_c, 64 bits: datapath result, {remainder, quotient} for divides and the product for multiplies.
REQ-011 The block SHALL have output busy, 1 bit: high while in RUN, used as the pipeline stall.
REQ-012 The block SHALL have output done, 1 bit: one-cycle pulse when HI/LO is updated by a mul/div.
REQ-013 The block SHALL have outputs hi and lo, 32 bits each: architectural HI and LO registers.

Function
REQ-014 The FSM SHALL have exactly two states, IDLE and RUN; busy SHALL be 1 if and only if the state is RUN.
REQ-015 In IDLE, start with op 000-011 SHALL latch a, b and op, load the counter with LAT-1, and enter RUN on the next edge.
REQ-016 alu2_op SHALL be mult->01, multu->00, div->11, divu->10; madd and msub SHALL use 01.
REQ-017 alu2_a, alu2_b and alu2_op SHALL stay stable for the whole of RUN.
REQ-018 In RUN, the counter SHALL decrement each cycle; when it is 0 the block SHALL write {hi,lo} <= alu2_c, pulse done, and return to IDLE, giving exactly LAT cycles of busy.
REQ-019 Division with b==0 SHALL not enter RUN; the block SHALL pulse done on the next cycle and leave HI/LO unchanged.
REQ-020 mthi and mtlo SHALL write hi or lo from a at the next edge, with no busy and no done; the other register SHALL be unchanged.
REQ-021 start during RUN SHALL be ignored; the requester SHALL hold start until busy is low.
REQ-022 cancel in RUN SHALL return the FSM to IDLE at the next edge with HI/LO unchanged and no done; cancel SHALL take priority over completion in the same cycle.
REQ-023 cancel and start together in IDLE SHALL drop the start, including mthi and mtlo.
REQ-024 The counter SHALL be 6 bits and SHALL never wrap, because it is reloaded on every acceptance.

Reset
REQ-025 When rst=1 at an edge, the block SHALL force state to IDLE, counter to 0, busy to 0, done to 0, hi and lo to 0, and alu2_a, alu2_b and alu2_op to 0; rst SHALL override start and cancel.
REQ-026 rst asserted mid-RUN SHALL abort the operation with no done pulse.

Configuration
REQ-027 With MDU_MADD_EN defined, madd SHALL perform {hi,lo} <= {hi,lo} + alu2_c and msub SHALL perform {hi,lo} <= {hi,lo} - alu2_c, using 64-bit modulo arithmetic and MUL_LAT latency.
REQ-028 Without MDU_MADD_EN, op 110 and 111 SHALL be ignored: no busy, no done, no state change.

Structure
REQ-029 The op encodings, alu2_op encodings and the IDLE/RUN state type SHALL be placed in the shared package mdu_pkg.
REQ-030 The latency counter MAY be a sub-module named mdu_lat_cnt, with load, value and zero flag; the FSM and HI/LO registers SHALL remain in mdu_ctrl.

Verification
REQ-031 The bench SHALL check: mult a=0xFFFFFFFE, b=3 -> busy for 4 cycles, then done, hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-032 The bench SHALL check: divu a=100, b=7 -> 33 busy cycles, then hi=2, lo=14; div a=-7, b=2 -> hi=0xFFFFFFFF, lo=0xFFFFFFFD.
REQ-033 The bench SHALL check: div with b=0 and prior hi=5, lo=6 -> done on the next cycle with no busy, and hi=5, lo=6 unchanged.
REQ-034 The bench SHALL check: cancel in the 3rd cycle of a divide -> busy low on the next cycle, no done, HI/LO unchanged; a following mtlo a=0x1234 -> lo=0x1234.
REQ-035 The bench SHALL check: cancel coinciding with the final RUN cycle -> no done and HI/LO unchanged; rst mid-RUN -> hi=lo=0 and busy=0.
REQ-036 The bench SHALL check: with MDU_MADD_EN, hi=0, lo=0xFFFFFFFF, madd a=1, b=1 -> hi=1, lo=0; without the macro, op 110 -> no busy and HI/LO unchanged.
